// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and BRAM write-port bundle for the instruction memory boot loader.
// The slave modport is the loader side; the master modport is the byte source / memory model side.
interface imem_boot_loader_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  s_valid;
   logic [7:0]            s_data;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] i_w_addr;
   logic [DATA_WIDTH-1:0] i_w_dat;
   logic                  i_w_enb;
   logic [3:0]            i_w_byte_enb;

   modport slave (
      input  s_valid, s_data,
      output s_ready, i_w_addr, i_w_dat, i_w_enb, i_w_byte_enb
   );

   modport master (
      output s_valid, s_data,
      input  s_ready, i_w_addr, i_w_dat, i_w_enb, i_w_byte_enb
   );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a little-endian byte stream (word count, then payload) into instruction BRAM
// writes while holding the core stalled. Optional trailing checksum: define IMEM_BOOT_LOADER_CHECKSUM_EN.
module imem_boot_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   imem_boot_loader_if.slave   bus,
   output logic                i_r_enb,
   output logic                core_stall,
   output logic                done,
   output logic                error
);
   localparam logic [DATA_WIDTH-1:0] MEM_WORDS_W = DATA_WIDTH'(MEM_WORDS);
   localparam logic [DATA_WIDTH-1:0] ONE_W       = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] ZERO_W      = DATA_WIDTH'(0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      ,ST_CSUM = 3'd6
`endif
   } state_t;

   state_t                state_q;
   logic [1:0]            byte_cnt_q;
   logic [DATA_WIDTH-9:0] shift_q;
   logic [DATA_WIDTH-1:0] len_q;
   logic [DATA_WIDTH-1:0] word_idx_q;
   logic                  s_ready_q;
   logic                  w_enb_q;
   logic [3:0]            w_be_q;
   logic [DATA_WIDTH-1:0] w_addr_q;
   logic [DATA_WIDTH-1:0] w_dat_q;
   logic                  r_enb_q;
   logic                  stall_q;
   logic                  done_q;
   logic                  err_q;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum_q;
`endif

   logic                  fire_d;
   logic                  last_byte_d;
   logic [DATA_WIDTH-1:0] word_d;
   logic [DATA_WIDTH-1:0] word_idx_inc_d;

   // Handshake and assembled-word helpers; the 4th byte completes word_d in the same cycle it arrives.
   always_comb begin
      fire_d         = bus.s_valid & s_ready_q;
      last_byte_d    = (byte_cnt_q == 2'd3);
      word_d         = {bus.s_data, shift_q};
      word_idx_inc_d = word_idx_q + ONE_W;
   end

   // Loader FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= 2'd0;
         shift_q    <= '0;
         len_q      <= ZERO_W;
         word_idx_q <= ZERO_W;
         s_ready_q  <= 1'b0;
         w_enb_q    <= 1'b0;
         w_be_q     <= 4'b0000;
         w_addr_q   <= ZERO_W;
         w_dat_q    <= ZERO_W;
         r_enb_q    <= 1'b0;
         stall_q    <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
         csum_q     <= ZERO_W;
`endif
      end else begin
         w_enb_q <= 1'b0;
         w_be_q  <= 4'b0000;
         if (fire_d) begin
            shift_q    <= word_d[DATA_WIDTH-1:8];
            byte_cnt_q <= byte_cnt_q + 2'd1;
         end
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state_q    <= ST_LEN;
                  s_ready_q  <= 1'b1;
                  stall_q    <= 1'b1;
                  r_enb_q    <= 1'b0;
                  done_q     <= 1'b0;
                  err_q      <= 1'b0;
                  word_idx_q <= ZERO_W;
                  byte_cnt_q <= 2'd0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                  csum_q     <= ZERO_W;
`endif
               end
            end
            ST_LEN: begin
               if (fire_d && last_byte_d) begin
                  len_q <= word_d;
                  if (word_d > MEM_WORDS_W) begin
                     state_q   <= ST_ERR;
                     s_ready_q <= 1'b0;
                     err_q     <= 1'b1;
                  end else if (word_d == ZERO_W) begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                     state_q   <= ST_CSUM;
`else
                     state_q   <= ST_DONE;
                     s_ready_q <= 1'b0;
                     stall_q   <= 1'b0;
                     r_enb_q   <= 1'b1;
                     done_q    <= 1'b1;
`endif
                  end else begin
                     state_q <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (fire_d && last_byte_d) begin
                  state_q   <= ST_WRITE;
                  s_ready_q <= 1'b0;
                  w_enb_q   <= 1'b1;
                  w_be_q    <= 4'b1111;
                  w_addr_q  <= {word_idx_q[DATA_WIDTH-3:0], 2'b00};
                  w_dat_q   <= word_d;
               end
            end
            ST_WRITE: begin
               word_idx_q <= word_idx_inc_d;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
               csum_q     <= csum_q + w_dat_q;
`endif
               if (word_idx_inc_d == len_q) begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                  state_q   <= ST_CSUM;
                  s_ready_q <= 1'b1;
`else
                  state_q   <= ST_DONE;
                  s_ready_q <= 1'b0;
                  stall_q   <= 1'b0;
                  r_enb_q   <= 1'b1;
                  done_q    <= 1'b1;
`endif
               end else begin
                  state_q   <= ST_DATA;
                  s_ready_q <= 1'b1;
               end
            end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (fire_d && last_byte_d) begin
                  s_ready_q <= 1'b0;
                  if (word_d == csum_q) begin
                     state_q <= ST_DONE;
                     stall_q <= 1'b0;
                     r_enb_q <= 1'b1;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_ERR;
                     err_q   <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state_q   <= ST_IDLE;
               s_ready_q <= 1'b0;
               stall_q   <= 1'b1;
               r_enb_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.s_ready      = s_ready_q;
   assign bus.i_w_enb      = w_enb_q;
   assign bus.i_w_byte_enb = w_be_q;
   assign bus.i_w_addr     = w_addr_q;
   assign bus.i_w_dat      = w_dat_q;
   assign i_r_enb          = r_enb_q;
   assign core_stall       = stall_q;
   assign done             = done_q;
   assign error            = err_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected BRAM writes are queued by the stimulus and
// checked by an independent write-port monitor; status levels are checked inline.
module tb_imem_boot_loader;
   logic clk = 1'b0;
   logic rst;
   logic start;
   logic i_r_enb;
   logic core_stall;
   logic done;
   logic error;

   imem_boot_loader_if #(.DATA_WIDTH(32)) bus ();

   imem_boot_loader #(.DATA_WIDTH(32), .MEM_WORDS(1024)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bus        (bus),
      .i_r_enb    (i_r_enb),
      .core_stall (core_stall),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] dat;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  checks = 0;
   int  errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Write-port monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.i_w_enb === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%08h dat 0x%08h expected no write",
                     bus.i_w_addr, bus.i_w_dat);
         end else begin
            mon_e = exp_q.pop_front();
            check("w_addr", bus.i_w_addr, mon_e.addr);
            check("w_dat", bus.i_w_dat, mon_e.dat);
            check("w_byte_enb", {28'd0, bus.i_w_byte_enb}, 32'h0000_000F);
         end
      end else begin
         check("w_byte_enb_idle", {28'd0, bus.i_w_byte_enb}, 32'h0000_0000);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      t = 0;
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      while (bus.s_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got s_ready=0 for 50 cycles expected 1");
      end
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      send_byte(w[7:0], gap);
      send_byte(w[15:8], gap);
      send_byte(w[23:16], gap);
      send_byte(w[31:24], gap);
   endtask

   // Without the checksum feature done rises on the second edge after the last payload byte.
   task automatic finish_image(input logic [31:0] sum);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      send_word(sum, 0);
`else
      check("done_early", {31'd0, done}, 32'd0);
      tick();
`endif
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.dat  = d;
      exp_q.push_back(e);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Idle after reset: {stall, r_enb, s_ready, done, error}
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_status", {27'd0, core_stall, i_r_enb, bus.s_ready, done, error}, 32'h10);
      end

      // Two-word image, continuous valid
      pulse_start();
      check("len_ready", {31'd0, bus.s_ready}, 32'd1);
      push_wr(32'h0, 32'h00A0_0513);
      push_wr(32'h4, 32'h00B0_0593);
      send_word(32'd2, 0);
      send_word(32'h00A0_0513, 0);
      send_word(32'h00B0_0593, 0);
      finish_image(32'h0150_0AA6);
      check("done_status", {29'd0, done, core_stall, i_r_enb}, 32'h5);
      check("done_ready", {31'd0, bus.s_ready}, 32'd0);
      check("writes_seen_1", exp_q.size(), 32'd0);

      // Same image with bubbles; a start during DATA must be ignored
      pulse_start();
      check("restart_clear", {30'd0, done, core_stall}, 32'h1);
      push_wr(32'h0, 32'h00A0_0513);
      push_wr(32'h4, 32'h00B0_0593);
      send_word(32'd2, 1);
      send_byte(8'h13, 1);
      pulse_start();
      send_byte(8'h05, 1);
      send_byte(8'hA0, 1);
      send_byte(8'h00, 1);
      send_word(32'h00B0_0593, 1);
      finish_image(32'h0150_0AA6);
      check("done_bubble", {29'd0, done, core_stall, i_r_enb}, 32'h5);
      check("writes_seen_2", exp_q.size(), 32'd0);

      // Empty image
      pulse_start();
      send_word(32'd0, 0);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      send_word(32'd0, 0);
`endif
      check("done_empty", {29'd0, done, core_stall, i_r_enb}, 32'h5);

      // Oversized length goes straight to error
      pulse_start();
      send_word(32'h0000_0401, 0);
      check("err_status", {28'd0, error, done, core_stall, bus.s_ready}, 32'hA);
      repeat (5) tick();
      check("err_held", {31'd0, error}, 32'd1);
      pulse_start();
      check("err_restart", {30'd0, error, bus.s_ready}, 32'h1);

      // Reset in the middle of a word, then a clean one-word image
      send_word(32'd1, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_reset", {27'd0, core_stall, i_r_enb, bus.s_ready, done, error}, 32'h10);
      pulse_start();
      push_wr(32'h0, 32'hDEAD_BEEF);
      send_word(32'd1, 0);
      send_word(32'hDEAD_BEEF, 0);
      finish_image(32'hDEAD_BEEF);
      check("done_after_reset", {29'd0, done, core_stall, i_r_enb}, 32'h5);
      check("writes_seen_3", exp_q.size(), 32'd0);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      // Wrong checksum
      pulse_start();
      push_wr(32'h0, 32'h00A0_0513);
      push_wr(32'h4, 32'h00B0_0593);
      send_word(32'd2, 0);
      send_word(32'h00A0_0513, 0);
      send_word(32'h00B0_0593, 0);
      send_word(32'h0, 0);
      check("csum_bad", {29'd0, error, done, core_stall}, 32'h5);
`endif

      // Full-depth image: last write lands at 0xFFC
      pulse_start();
      send_word(32'd1024, 0);
      for (int i = 0; i < 1024; i++) begin
         push_wr(32'(i) << 2, 32'(i));
         send_word(32'(i), 0);
      end
      finish_image(32'h0007_FE00);
      check("done_full", {29'd0, done, core_stall, i_r_enb}, 32'h5);

      repeat (3) tick();
      check("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time controller for the core's instruction BRAM: receives a byte stream over a valid/ready handshake, packs it into 32-bit little-endian words, and drives the BRAM write port (w_addr/w_dat/w_enb/byte_enb).
- Holds the core stalled and the BRAM read port disabled while loading; releases both once the image is written.
- Sits between an external byte source (UART receiver, JTAG bridge) and the I_MEM write port plus the PC stall input.

Parameters:
- DATA_WIDTH, 32, BRAM word and address width.
- MEM_WORDS, 1024, instruction BRAM depth in 32-bit words; images longer than this are rejected.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse; begins a new load from IDLE, DONE or ERR.
- s_valid  in  1  byte source has data.
- s_data  in  8  stream byte.
- s_ready  out  1  loader accepts a byte this cycle.
- i_w_addr  out  DATA_WIDTH  BRAM byte address, always word-aligned.
- i_w_dat  out  DATA_WIDTH  packed word.
- i_w_enb  out  1  BRAM write strobe.
- i_w_byte_enb  out  4  byte enables; 4'b1111 whenever i_w_enb=1, else 4'b0000.
- i_r_enb  out  1  BRAM read enable for fetch.
- core_stall  out  1  drives PC stall.
- done  out  1  image loaded; level signal.
- error  out  1  load aborted; level signal.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE.
  - s_ready=0, i_w_enb=0, i_w_byte_enb=0, i_w_addr=0, i_w_dat=0.
  - i_r_enb=0, core_stall=1, done=0, error=0.
  - Byte counter, word counter and length register are cleared.
  - Reset overrides everything, including mid-load; a partially written image is abandoned, and BRAM contents are not cleared.
- Handshake:
  - A byte transfers on any edge where s_valid=1 and s_ready=1.
  - s_ready is a registered output and does not depend combinationally on s_valid.
- Stream format:
  - 4-byte little-endian word count N.
  - Then N×4 payload bytes, little-endian per word. The first byte received goes to bits [7:0].
- States:
  - IDLE: s_ready=0, core_stall=1. On start, go to LEN.
  - LEN: s_ready=1. Collect 4 bytes into N.
    - After the 4th byte: if N > MEM_WORDS, go to ERR.
    - Else if N=0, go to DONE.
    - Else go to DATA.
  - DATA: s_ready=1. Collect 4 bytes into the word buffer. The cycle after the 4th byte is accepted, go to WRITE.
  - WRITE (exactly one cycle):
    - s_ready=0, i_w_enb=1, i_w_addr = word_idx×4, i_w_dat = buffer.
    - Then increment word_idx.
    - If word_idx+1 == N, go to DONE; else go back to DATA.
  - DONE: s_ready=0, core_stall=0, i_r_enb=1, done=1. On start, go to LEN; clear done, word_idx and error, and reassert core_stall in the same edge.
  - ERR: s_ready=0, core_stall=1, i_r_enb=0, error=1. Only start or rst leaves this state; start goes to LEN.
- Timing:
  - Minimum 5 cycles per word (4 accept + 1 write).
  - Latency from the last payload byte accepted to done=1 is 2 edges.
- Boundary conditions:
  - start while in LEN/DATA/WRITE is ignored.
  - s_valid gaps (bubbles) between bytes are legal at any point; partial word state is held.
  - N == MEM_WORDS is legal; the last write goes to address (MEM_WORDS−1)×4.
  - Width rules: word_idx and N are DATA_WIDTH wide, compared unsigned; no wrap is possible because N ≤ MEM_WORDS is checked before any write.
  - start and rst in the same cycle: rst wins.

Optional Feature:
- Macro: IMEM_BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, go to state CSUM (s_ready=1) and receive 4 more little-endian bytes.
  - Compare them against the mod-2^32 sum of all N payload words, accumulated at each WRITE.
  - Match → DONE; mismatch → ERR.
  - N=0 also requires a checksum word of 0x00000000.
  - done assertion is 4 byte-accepts later than without the macro.
- Undefined: no CSUM state, no accumulator; behaviour exactly as above.

Test Plan:
- Reset release, no start → core_stall=1, i_r_enb=0, s_ready=0, done=0 held for 20 cycles; no i_w_enb pulse.
- start, stream 02 00 00 00 | 13 05 A0 00 | 93 05 B0 00, s_valid continuous:
  - i_w_enb pulses twice: addr 0x0 / dat 0x00A00513, then addr 0x4 / dat 0x00B00593, byte_enb=4'hF on both.
  - done=1, core_stall=0, i_r_enb=1 two edges after the last byte.
- Same stream with s_valid toggled 1-0-1 per byte:
  - Identical writes and data; s_ready never drops outside WRITE.
- Length 0x00000401 with MEM_WORDS=1024:
  - error=1 after the 4th length byte; no write pulses; s_ready=0.
  - A subsequent start returns s_ready=1 and clears error.
- rst asserted mid-DATA after 2 of 4 bytes, then start, then a full 1-word image 01 00 00 00 EF BE AD DE:
  - A single write of 0xDEADBEEF at addr 0x0, with no stale bytes.
- With IMEM_BOOT_LOADER_CHECKSUM_EN:
  - The 2-word image above plus checksum A6 0A 50 01 (0x01500AA6) → done=1.
  - Checksum 00 00 00 00 → error=1, core_stall=1.
